// File: rtl/pulse_pkg.sv
// Shared definitions for the stretched-pulse link (stretcher and recovery sides).
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_STUCK  = 2'd3
  } pulse_state_e;

  function automatic int f_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser with asynchronous active-low reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_recover.sv
// Recovers a 1-cycle event from a stretched pulse level, measuring its width and
// flagging glitches (too short) and stuck levels (too long).
//
//   state  | meaning
//   IDLE   | waiting for synchronised input to go high
//   QUAL   | high, fewer than MIN_CNT samples seen so far
//   ACTIVE | qualified pulse, counting its width
//   STUCK  | high for MAX_CNT samples; counter saturated, err_stuck asserted
module pulse_recover
  import pulse_pkg::*;
#(
  parameter  int SYNC_STAGES = 2,
  parameter  int MIN_CNT     = 3,
  parameter  int MAX_CNT     = 64,
  localparam int CNT_W       = f_clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             signal_in,
  output logic             signal_out,
  output logic [CNT_W-1:0] width_out,
  output logic             width_valid,
  output logic             err_short,
  output logic             err_stuck
);

  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  logic             s;
  pulse_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, width_nxt;
  logic             strobe_nxt, short_nxt, wv_nxt, stuck_nxt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (signal_in),
    .q     (s)
  );

  // Saturating increment; the counter must never wrap past MAX_CNT.
  assign cnt_inc = (cnt == MAX_V) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      signal_out  <= 1'b0;
      width_out   <= '0;
      width_valid <= 1'b0;
      err_short   <= 1'b0;
      err_stuck   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      signal_out  <= strobe_nxt;
      width_out   <= width_nxt;
      width_valid <= wv_nxt;
      err_short   <= short_nxt;
      err_stuck   <= stuck_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    width_nxt  = width_out;
    strobe_nxt = 1'b0;
    short_nxt  = 1'b0;
    wv_nxt     = 1'b0;
    stuck_nxt  = err_stuck;
    case (state)
      ST_IDLE: begin
        if (s) begin
          cnt_nxt = CNT_W'(1);
          if (MIN_CNT == 1) begin
            state_nxt  = ST_ACTIVE;
            strobe_nxt = 1'b1;
          end else begin
            state_nxt = ST_QUAL;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_QUAL: begin
        if (s) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == MIN_V) begin
            state_nxt  = ST_ACTIVE;
            strobe_nxt = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (s) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == MAX_V) begin
            state_nxt = ST_STUCK;
            stuck_nxt = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          width_nxt = cnt;
          wv_nxt    = 1'b1;
        end
      end
      ST_STUCK: begin
        if (s) begin
          cnt_nxt = MAX_V;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          stuck_nxt = 1'b0;
          width_nxt = MAX_V;
          wv_nxt    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_recover.sv
// Directed bench for pulse_recover at defaults plus a MIN_CNT=1 instance.
module tb_pulse_recover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       signal_in = 1'b0;

  logic       signal_out, width_valid, err_short, err_stuck;
  logic [6:0] width_out;
  logic       signal_out1, width_valid1, err_short1, err_stuck1;
  logic [6:0] width_out1;

  int vecs = 0;
  int misc = 0;

  // per-test observations, edge index k counts posedges from the first driven cycle
  int k;
  int so_n, so_edge, wv_n, wv_edge, es_n, es_edge, multi;
  int stuck_rise, stuck_fall;
  logic stuck_prev;
  logic [6:0] widths[$];
  int so1_n, so1_first, wv1_n, wv1_edge;
  logic [6:0] widths1[$];

  pulse_recover #(.SYNC_STAGES(2), .MIN_CNT(3), .MAX_CNT(64)) dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
    .signal_out(signal_out), .width_out(width_out), .width_valid(width_valid),
    .err_short(err_short), .err_stuck(err_stuck)
  );

  pulse_recover #(.SYNC_STAGES(2), .MIN_CNT(1), .MAX_CNT(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
    .signal_out(signal_out1), .width_out(width_out1), .width_valid(width_valid1),
    .err_short(err_short1), .err_stuck(err_stuck1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr_obs();
    k = 0; so_n = 0; so_edge = -1; wv_n = 0; wv_edge = -1; es_n = 0; es_edge = -1;
    multi = 0; stuck_rise = -1; stuck_fall = -1; stuck_prev = err_stuck;
    widths.delete();
    so1_n = 0; so1_first = -1; wv1_n = 0; wv1_edge = -1;
    widths1.delete();
  endtask

  // Drive one input sample, let it be captured, then record what the outputs show.
  task automatic cyc(input logic v);
    signal_in = v;
    @(posedge clk);
    #1;
    if (signal_out) begin so_n++; so_edge = k; end
    if (width_valid) begin wv_n++; wv_edge = k; widths.push_back(width_out); end
    if (err_short) begin es_n++; es_edge = k; end
    if (err_stuck && !stuck_prev) stuck_rise = k;
    if (!err_stuck && stuck_prev) stuck_fall = k;
    stuck_prev = err_stuck;
    if ((int'(signal_out) + int'(width_valid) + int'(err_short)) > 1) multi++;
    if (signal_out1) begin so1_n++; if (so1_first < 0) so1_first = k; end
    if (width_valid1) begin wv1_n++; wv1_edge = k; widths1.push_back(width_out1); end
    k++;
  endtask

  task automatic cycs(input logic v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (signal_out !== 1'b0) begin misc++; $display("FAIL reset_signal_out got %b want 0", signal_out); end
    vecs++; if (width_out !== 7'd0) begin misc++; $display("FAIL reset_width_out got %0d want 0", width_out); end
    vecs++; if (width_valid !== 1'b0) begin misc++; $display("FAIL reset_width_valid got %b want 0", width_valid); end
    vecs++; if (err_short !== 1'b0) begin misc++; $display("FAIL reset_err_short got %b want 0", err_short); end
    vecs++; if (err_stuck !== 1'b0) begin misc++; $display("FAIL reset_err_stuck got %b want 0", err_stuck); end
    vecs++; if (width_out1 !== 7'd0) begin misc++; $display("FAIL reset_width_out1 got %0d want 0", width_out1); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clr_obs();
    cycs(1'b0, 4);
    vecs++; if (so_n + wv_n + es_n !== 0) begin misc++; $display("FAIL idle_strobes got %0d want 0", so_n + wv_n + es_n); end
  endtask

  task automatic test_single();
    clr_obs();
    cycs(1'b1, 4);
    cycs(1'b0, 8);
    vecs++; if (so_n !== 1) begin misc++; $display("FAIL single_so_count got %0d want 1", so_n); end
    vecs++; if (so_edge !== 4) begin misc++; $display("FAIL single_so_edge got %0d want 4", so_edge); end
    vecs++; if (wv_n !== 1) begin misc++; $display("FAIL single_wv_count got %0d want 1", wv_n); end
    vecs++; if (wv_edge !== 6) begin misc++; $display("FAIL single_wv_edge got %0d want 6", wv_edge); end
    vecs++; if (wv_n > 0 && widths[0] !== 7'd4) begin misc++; $display("FAIL single_width got %0d want 4", widths[0]); end
    vecs++; if (es_n !== 0 || stuck_rise !== -1) begin misc++; $display("FAIL single_errors got short=%0d stuck_rise=%0d want 0/-1", es_n, stuck_rise); end
    vecs++; if (multi !== 0) begin misc++; $display("FAIL single_exclusive got %0d want 0", multi); end
    vecs++; if (width_out !== 7'd4) begin misc++; $display("FAIL single_width_hold got %0d want 4", width_out); end
  endtask

  task automatic test_short();
    clr_obs();
    cycs(1'b1, 2);
    cycs(1'b0, 8);
    vecs++; if (es_n !== 1) begin misc++; $display("FAIL short_count got %0d want 1", es_n); end
    vecs++; if (es_edge !== 4) begin misc++; $display("FAIL short_edge got %0d want 4", es_edge); end
    vecs++; if (so_n !== 0) begin misc++; $display("FAIL short_no_so got %0d want 0", so_n); end
    vecs++; if (wv_n !== 0) begin misc++; $display("FAIL short_no_wv got %0d want 0", wv_n); end
    vecs++; if (width_out !== 7'd4) begin misc++; $display("FAIL short_width_unchanged got %0d want 4", width_out); end
  endtask

  task automatic test_back_to_back();
    clr_obs();
    cycs(1'b1, 3);
    cycs(1'b0, 1);
    cycs(1'b1, 5);
    cycs(1'b0, 8);
    vecs++; if (so_n !== 2) begin misc++; $display("FAIL b2b_so_count got %0d want 2", so_n); end
    vecs++; if (so_edge !== 8) begin misc++; $display("FAIL b2b_so_edge got %0d want 8", so_edge); end
    vecs++; if (wv_n !== 2) begin misc++; $display("FAIL b2b_wv_count got %0d want 2", wv_n); end
    vecs++; if (wv_n == 2 && widths[0] !== 7'd3) begin misc++; $display("FAIL b2b_width0 got %0d want 3", widths[0]); end
    vecs++; if (wv_n == 2 && widths[1] !== 7'd5) begin misc++; $display("FAIL b2b_width1 got %0d want 5", widths[1]); end
    vecs++; if (wv_edge !== 11) begin misc++; $display("FAIL b2b_wv_edge got %0d want 11", wv_edge); end
    vecs++; if (es_n !== 0 || multi !== 0) begin misc++; $display("FAIL b2b_clean got short=%0d multi=%0d want 0/0", es_n, multi); end
  endtask

  task automatic test_stuck();
    clr_obs();
    cycs(1'b1, 70);
    cycs(1'b0, 8);
    vecs++; if (so_n !== 1) begin misc++; $display("FAIL stuck_so_count got %0d want 1", so_n); end
    vecs++; if (stuck_rise !== 65) begin misc++; $display("FAIL stuck_rise_edge got %0d want 65", stuck_rise); end
    vecs++; if (stuck_fall !== 72) begin misc++; $display("FAIL stuck_fall_edge got %0d want 72", stuck_fall); end
    vecs++; if (wv_n !== 1 || wv_edge !== 72) begin misc++; $display("FAIL stuck_wv got n=%0d edge=%0d want 1/72", wv_n, wv_edge); end
    vecs++; if (wv_n > 0 && widths[0] !== 7'd64) begin misc++; $display("FAIL stuck_width got %0d want 64", widths[0]); end
    vecs++; if (err_stuck !== 1'b0) begin misc++; $display("FAIL stuck_cleared got %b want 0", err_stuck); end
  endtask

  task automatic test_reset_mid();
    clr_obs();
    cycs(1'b1, 5);
    vecs++; if (signal_out !== 1'b1) begin misc++; $display("FAIL rstmid_pre_so got %b want 1", signal_out); end
    rst_n = 1'b0;
    #1;
    vecs++; if (signal_out !== 1'b0) begin misc++; $display("FAIL rstmid_so_clear got %b want 0", signal_out); end
    vecs++; if (width_out !== 7'd0) begin misc++; $display("FAIL rstmid_width_clear got %0d want 0", width_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_obs();
    cycs(1'b1, 5);
    cycs(1'b0, 8);
    vecs++; if (so_n !== 1 || so_edge !== 4) begin misc++; $display("FAIL rstmid_so got n=%0d edge=%0d want 1/4", so_n, so_edge); end
    vecs++; if (wv_n !== 1 || wv_edge !== 7) begin misc++; $display("FAIL rstmid_wv got n=%0d edge=%0d want 1/7", wv_n, wv_edge); end
    vecs++; if (wv_n > 0 && widths[0] !== 7'd5) begin misc++; $display("FAIL rstmid_width got %0d want 5", widths[0]); end
  endtask

  task automatic test_min1();
    clr_obs();
    for (int p = 0; p < 6; p++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    cycs(1'b0, 8);
    vecs++; if (so1_n !== 6) begin misc++; $display("FAIL min1_so_count got %0d want 6", so1_n); end
    vecs++; if (so1_first !== 2) begin misc++; $display("FAIL min1_so_first got %0d want 2", so1_first); end
    vecs++; if (wv1_n !== 6) begin misc++; $display("FAIL min1_wv_count got %0d want 6", wv1_n); end
    vecs++; if (wv1_edge !== 13) begin misc++; $display("FAIL min1_wv_last_edge got %0d want 13", wv1_edge); end
    foreach (widths1[i]) begin
      vecs++; if (widths1[i] !== 7'd1) begin misc++; $display("FAIL min1_width[%0d] got %0d want 1", i, widths1[i]); end
    end
    vecs++; if (es_n !== 6 || so_n !== 0) begin misc++; $display("FAIL min3_glitches got short=%0d so=%0d want 6/0", es_n, so_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_short();
    test_back_to_back();
    test_stuck();
    test_reset_mid();
    test_min1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

endmodule
